// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared types and constants for the SPI-RAM initiator
package shared_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  localparam logic SLAVE_SELECTED   = 1'b0;
  localparam logic SLAVE_DESELECTED = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_END
  } master_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - 10-bit parallel-load TX shifter and MISO receive shifter
import shared_pkg::*;

module spi_master_shifter (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_frame,
  input  logic                  shift_tx,
  input  logic                  shift_rx,
  input  logic                  miso_bit,
  output logic                  tx_msb,
  output logic [DATA_BITS-1:0]  rx_byte
);

  logic [FRAME_BITS-1:0] tx;
  // Only the first seven received bits need storage; the eighth is taken
  // straight from MISO in the cycle the byte completes.
  logic [DATA_BITS-2:0]  rx;

  // TX register: loaded at accept, shifted left MSB-first while sending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx <= '0;
    end else if (load) begin
      tx <= load_frame;
    end else if (shift_tx) begin
      tx <= {tx[FRAME_BITS-2:0], 1'b0};
    end
  end

  // RX register: collects MISO MSB-first during the receive window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx <= '0;
    end else if (shift_rx) begin
      rx <= {rx[DATA_BITS-3:0], miso_bit};
    end
  end

  assign tx_msb  = tx[FRAME_BITS-1];
  assign rx_byte = {rx, miso_bit};

endmodule

// File: rtl/spi_ram_master.sv
// rtl/spi_ram_master.sv - SPI initiator turning command requests into SS_n/MOSI frames
import shared_pkg::*;

module spi_ram_master #(
  parameter int MISO_DELAY = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [3:0] SEND_LAST = 4'(FRAME_BITS);
  localparam logic [3:0] RECV_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] WAIT_LAST = 4'(MISO_DELAY - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  master_state_e         state;
  logic [3:0]            cnt;
  logic                  is_read;
  logic                  accept;
  logic                  req_is_read;
  logic [FRAME_BITS-1:0] frame_in;
  logic                  tx_msb;
  logic [DATA_BITS-1:0]  rx_byte;

  assign accept      = (state == ST_IDLE) && req_ready && req_valid;
  assign req_is_read = (spi_cmd_e'(req_cmd) == RD_DATA);
  assign frame_in    = {req_cmd, req_is_read ? 8'h00 : req_data};

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_frame (frame_in),
    .shift_tx   ((state == ST_SEND) && (cnt != SEND_LAST)),
    .shift_rx   (state == ST_RECV),
    .miso_bit   (MISO),
    .tx_msb     (tx_msb),
    .rx_byte    (rx_byte)
  );

  // Frame sequencer: IDLE, lead cycle, 11 send cycles, optional read window, deselect gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      is_read   <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      SS_n      <= SLAVE_DESELECTED;
      MOSI      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_START;
            is_read   <= req_is_read;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            SS_n      <= SLAVE_SELECTED;
            MOSI      <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_START: begin
          // First send cycle repeats frame[9] as the slave's path-select bit
          state <= ST_SEND;
          cnt   <= '0;
          MOSI  <= tx_msb;
        end
        ST_SEND: begin
          if (cnt == SEND_LAST) begin
            cnt  <= '0;
            MOSI <= 1'b0;
            if (!is_read) begin
              state <= ST_END;
              SS_n  <= SLAVE_DESELECTED;
            end else if (MISO_DELAY == 0) begin
              state <= ST_RECV;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            cnt  <= cnt + 4'd1;
            MOSI <= tx_msb;
          end
        end
        ST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= ST_RECV;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RECV: begin
          if (cnt == RECV_LAST) begin
            state     <= ST_END;
            cnt       <= '0;
            SS_n      <= SLAVE_DESELECTED;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_byte;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_END: begin
          if (cnt == GAP_LAST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// tb/tb_spi_ram_master.sv - self-checking bench for spi_ram_master with SPI-RAM slave model
module tb_spi_ram_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_cmd = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       MISO = 1'b0;
  logic       req_ready, rsp_valid, busy, SS_n, MOSI;
  logic [7:0] rsp_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_ram_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and bus monitor: sees the bus as the slave would (value held before each posedge)
  int         lo_cnt = 0;
  int         hi_run = 0;
  int         min_gap = 1000;
  int         last_len = 0;
  int         frames_seen = 0;
  int         rsp_count = 0;
  int         rsp_cyc = 0;
  int         rise_cyc = 0;
  int         hs_count = 0;
  bit         ready_in_frame = 0;
  bit         override_en = 0;
  logic [7:0] override_val = 8'h00;
  logic [11:0] bits = '0;
  logic [11:0] last_bits = '0;
  logic [7:0] s_mem [256];
  logic [7:0] s_addr = 8'h00;
  logic [7:0] reply = 8'h00;
  logic [9:0] frame_q [$];
  logic [7:0] rsp_q [$];

  always @(negedge clk) begin
    if (rst) begin
      lo_cnt = 0;
      MISO = 1'b0;
      for (int i = 0; i < 256; i++) s_mem[i] = 8'h00;
    end else begin
      if (req_valid && req_ready) hs_count++;
      if (rsp_valid) begin
        rsp_count++;
        rsp_q.push_back(rsp_data);
        rsp_cyc = cyc;
      end
      if (SS_n == 1'b0) begin
        if (lo_cnt == 0 && hi_run < min_gap) min_gap = hi_run;
        hi_run = 0;
        lo_cnt++;
        if (req_ready) ready_in_frame = 1;
        if (lo_cnt <= 12) bits[12 - lo_cnt] = MOSI;
        if (lo_cnt == 12) begin
          last_bits = bits;
          frame_q.push_back(bits[9:0]);
          frames_seen++;
          case (bits[9:8])
            2'b00: s_addr = bits[7:0];
            2'b01: s_mem[s_addr] = bits[7:0];
            2'b10: s_addr = bits[7:0];
            default: reply = override_en ? override_val : s_mem[s_addr];
          endcase
        end
        if (lo_cnt >= 15 && lo_cnt <= 22) MISO = reply[22 - lo_cnt];
        else MISO = 1'b0;
      end else begin
        if (lo_cnt != 0) begin
          rise_cyc = cyc;
          last_len = lo_cnt;
        end
        lo_cnt = 0;
        hi_run++;
        MISO = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [1:0] cmd, input logic [7:0] data, output int acc);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_data  = data;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout got req_ready=%0b want 1", req_ready);
    end
    @(posedge clk); #1;
    acc       = cyc;
    req_valid = 1'b0;
    req_cmd   = 2'($urandom);
    req_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || !req_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout got busy=%0b want 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL rst_ss_n got %b want 1", SS_n); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", MOSI); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL rst_rsp_data got %h want 00", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
  endtask

  task automatic test_wr_addr_a5();
    int acc, f0;
    f0 = frames_seen;
    do_req(2'b00, 8'hA5, acc);
    wait_idle();
    checks++; if (frames_seen !== f0 + 1) begin errors++; $display("FAIL a5_frames got %0d want %0d", frames_seen, f0 + 1); end
    checks++; if (last_bits !== 12'b0000_1010_0101) begin errors++; $display("FAIL a5_mosi got %b want 000010100101", last_bits); end
    checks++; if (last_len !== 12) begin errors++; $display("FAIL a5_ss_low got %0d want 12", last_len); end
    checks++; if (rise_cyc - acc !== 12) begin errors++; $display("FAIL a5_latency got %0d want 12", rise_cyc - acc); end
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL a5_ss_after got %b want 1", SS_n); end
  endtask

  task automatic test_write_read();
    int acc, r0;
    do_req(2'b00, 8'h10, acc); wait_idle();
    do_req(2'b01, 8'h3C, acc); wait_idle();
    do_req(2'b10, 8'h10, acc); wait_idle();
    r0 = rsp_count;
    do_req(2'b11, 8'hFF, acc); wait_idle();
    checks++; if (frame_q[$] !== 10'h300) begin errors++; $display("FAIL wr_rd_frame got %h want 300", frame_q[$]); end
    checks++; if (rsp_count !== r0 + 1) begin errors++; $display("FAIL wr_rd_rsp_count got %0d want %0d", rsp_count - r0, 1); end
    checks++; if (rsp_data !== 8'h3C) begin errors++; $display("FAIL wr_rd_data got %h want 3c", rsp_data); end
  endtask

  task automatic test_read_latency();
    int acc;
    override_en  = 1;
    override_val = 8'h81;
    do_req(2'b11, 8'($urandom), acc);
    wait_idle();
    override_en = 0;
    checks++; if (rsp_q[$] !== 8'h81) begin errors++; $display("FAIL rd81_data got %h want 81", rsp_q[$]); end
    checks++; if (rsp_cyc - acc !== 22) begin errors++; $display("FAIL rd81_rsp_latency got %0d want 22", rsp_cyc - acc); end
    checks++; if (rise_cyc - acc !== 22) begin errors++; $display("FAIL rd81_ss_latency got %0d want 22", rise_cyc - acc); end
  endtask

  task automatic test_random();
    int acc, r0;
    logic [7:0] model [256];
    logic [7:0] addrs [$];
    logic [7:0] a, d, pick;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      model[a] = d;
      addrs.push_back(a);
      do_req(2'b00, a, acc); wait_idle();
      checks++; if (frame_q[$] !== {2'b00, a}) begin errors++; $display("FAIL rnd_wa_frame got %h want %h", frame_q[$], {2'b00, a}); end
      do_req(2'b01, d, acc); wait_idle();
      checks++; if (frame_q[$] !== {2'b01, d}) begin errors++; $display("FAIL rnd_wd_frame got %h want %h", frame_q[$], {2'b01, d}); end
    end
    for (int i = 0; i < 10; i++) begin
      pick = addrs[$urandom_range(0, addrs.size() - 1)];
      do_req(2'b10, pick, acc); wait_idle();
      checks++; if (frame_q[$] !== {2'b10, pick}) begin errors++; $display("FAIL rnd_ra_frame got %h want %h", frame_q[$], {2'b10, pick}); end
      r0 = rsp_q.size();
      do_req(2'b11, 8'($urandom), acc); wait_idle();
      checks++; if (rsp_q.size() !== r0 + 1) begin errors++; $display("FAIL rnd_rsp_count got %0d want %0d", rsp_q.size(), r0 + 1); end
      else begin
        checks++; if (rsp_q[$] !== model[pick]) begin errors++; $display("FAIL rnd_rd_data got %h want %h", rsp_q[$], model[pick]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int hs, n, f0;
    f0 = frames_seen;
    min_gap = 1000;
    ready_in_frame = 0;
    hs = 0;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_cmd   = 2'b01;
    req_data  = 8'($urandom);
    while (hs < 3 && n < 300) begin
      if (req_ready) hs++;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    wait_idle();
    checks++; if (frames_seen !== f0 + 3) begin errors++; $display("FAIL b2b_frames got %0d want %0d", frames_seen - f0, 3); end
    checks++; if (min_gap < 1) begin errors++; $display("FAIL b2b_gap got %0d want >=1", min_gap); end
    checks++; if (ready_in_frame !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_frame got %b want 0", ready_in_frame); end
  endtask

  task automatic test_reset_midframe();
    int acc, r0, f0;
    r0 = rsp_count;
    f0 = frames_seen;
    do_req(2'b11, 8'h00, acc);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL mid_rst_ss_n got %b want 1", SS_n); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL mid_rst_mosi got %b want 0", MOSI); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (rsp_count !== r0) begin errors++; $display("FAIL mid_rst_rsp got %0d want %0d", rsp_count, r0); end
    checks++; if (frames_seen !== f0) begin errors++; $display("FAIL mid_rst_partial got %0d want %0d", frames_seen, f0); end
    do_req(2'b00, 8'h5A, acc); wait_idle();
    checks++; if (last_bits !== {2'b00, 10'h05A}) begin errors++; $display("FAIL mid_rst_next got %b want %b", last_bits, {2'b00, 10'h05A}); end
  endtask

  task automatic test_busy_ignore();
    int acc, f0, h0;
    f0 = frames_seen;
    h0 = hs_count;
    do_req(2'b00, 8'($urandom), acc);
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_cmd   = 2'($urandom);
      req_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_idle();
    checks++; if (hs_count - h0 !== 1) begin errors++; $display("FAIL busy_hs got %0d want 1", hs_count - h0); end
    checks++; if (frames_seen - f0 !== hs_count - h0) begin errors++; $display("FAIL busy_frames got %0d want %0d", frames_seen - f0, hs_count - h0); end
  endtask

  initial begin
    test_reset();
    test_wr_addr_a5();
    test_write_read();
    test_read_latency();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
